// File: rtl/mdu.sv
// Iterative multiply/divide unit. One partial product or one quotient bit per cycle on operand
// magnitudes. The signs are applied in a final cycle, so the latency is fixed for every op.
module mdu #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic [3:0]       flags
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [2:0] OpMul    = 3'd0;
   localparam logic [2:0] OpMulh   = 3'd1;
   localparam logic [2:0] OpMulhsu = 3'd2;
   localparam logic [2:0] OpDiv    = 3'd4;
   localparam logic [2:0] OpDivu   = 3'd5;
   localparam logic [2:0] OpRem    = 3'd6;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           r_state, w_state_next;
   logic [CW-1:0]    r_cnt;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_hi, r_lo, r_b;
   logic             r_neg, r_dz, r_ov;
   logic [WIDTH-1:0] r_res;
   logic [3:0]       r_flags;

   // Operand decode at capture time
   logic             w_sa, w_sb, w_neg, w_dz, w_ov;
   logic [WIDTH-1:0] w_ma, w_mb;

   assign w_sa  = (op == OpMulh || op == OpMulhsu || op == OpDiv || op == OpRem) & a[WIDTH-1];
   assign w_sb  = (op == OpMulh || op == OpDiv || op == OpRem) & b[WIDTH-1];
   assign w_ma  = w_sa ? -a : a;
   assign w_mb  = w_sb ? -b : b;
   // Remainder takes the dividend sign; products and quotients the XOR of both signs
   assign w_neg = (op == OpRem) ? w_sa : (w_sa ^ w_sb);
   assign w_dz  = op[2] && (b == '0);
   assign w_ov  = (op == OpDiv || op == OpRem) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

   // One iteration step: shift-add for multiply, restoring subtract for divide
   logic [WIDTH:0]   w_sum, w_shift;
   logic [WIDTH-1:0] w_sub;
   logic             w_ge;

   assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
   assign w_shift = {r_hi, r_lo[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, r_b});
   // When w_ge holds the true difference is below r_b, so the low WIDTH bits are exact
   assign w_sub   = w_shift[WIDTH-1:0] - r_b;

   // Final result with sign correction and divide-by-zero override
   logic [2*WIDTH-1:0] w_prod_s;
   logic [WIDTH-1:0]   w_quo, w_rem, w_fin;
   logic [3:0]         w_fin_flags;

   assign w_prod_s = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
   assign w_quo    = r_neg ? -r_lo : r_lo;
   assign w_rem    = r_neg ? -r_hi : r_hi;

   // Select the result word for the captured op
   always_comb begin
      w_fin = '0;
      case (r_op)
         OpMul:          w_fin = w_prod_s[WIDTH-1:0];
         OpDiv, OpDivu:  w_fin = r_dz ? '1 : w_quo;
         OpRem, 3'd7:    w_fin = w_rem;
         default:        w_fin = w_prod_s[2*WIDTH-1:WIDTH];
      endcase
   end

   assign w_fin_flags = {w_fin[WIDTH-1], (w_fin == '0), r_dz, r_ov};

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= StIdle;
      else     r_state <= w_state_next;
   end

   // Next-state and status outputs
   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         StIdle: if (start) w_state_next = StRun;
         StRun: begin
            busy = 1'b1;
            if (r_cnt == CW'(WIDTH)) w_state_next = StDone;
         end
         StDone: begin
            busy         = 1'b1;
            done         = 1'b1;
            w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Datapath: capture, WIDTH iterations, then one finalize cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_op    <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_b     <= '0;
         r_neg   <= 1'b0;
         r_dz    <= 1'b0;
         r_ov    <= 1'b0;
         r_res   <= '0;
         r_flags <= 4'b0100;
      end else begin
         case (r_state)
            StIdle: begin
               if (start) begin
                  r_cnt <= '0;
                  r_op  <= op;
                  r_hi  <= '0;
                  r_lo  <= op[2] ? w_ma : w_mb;
                  r_b   <= op[2] ? w_mb : w_ma;
                  r_neg <= w_neg;
                  r_dz  <= w_dz;
                  r_ov  <= w_ov;
               end
            end
            StRun: begin
               if (r_cnt == CW'(WIDTH)) begin
                  r_res   <= w_fin;
                  r_flags <= w_fin_flags;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_op[2]) begin
                     r_hi <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                     r_lo <= {r_lo[WIDTH-2:0], w_ge};
                  end else begin
                     r_hi <= w_sum[WIDTH:1];
                     r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign res   = r_res;
   assign flags = r_flags;

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: 8..64, even).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only while busy=0.
REQ-005 SHALL have port op  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL have port a  input  WIDTH  operand a (rs1); MULHSU treats a signed, b unsigned.
REQ-007 SHALL have port b  input  WIDTH  operand b (rs2).
REQ-008 SHALL have port busy  output  1  operation in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; res/flags valid.
REQ-010 SHALL have port res  output  WIDTH  result.
REQ-011 SHALL have port flags  output  4  {N, Z, C, V}: N = res MSB, Z = res==0, C = divide-by-zero, V = signed divide overflow.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; IDLE->RUN on start=1; RUN->DONE after WIDTH iteration cycles; DONE->IDLE unconditionally.
REQ-013 SHALL capture op, a, b on the edge where start=1 in IDLE; later input changes SHALL NOT affect the result.
REQ-014 SHALL assert busy in RUN and DONE; busy=0 only in IDLE.
REQ-015 SHALL have fixed latency: start sampled at edge k -> done=1 for exactly the cycle after edge k+WIDTH+1, independent of op and operand values.
REQ-016 SHALL ignore start while busy=1 (no queuing, no restart).
REQ-017 SHALL compute MUL as low WIDTH bits, MULH/MULHSU/MULHU as high WIDTH bits of the 2*WIDTH product, with iterative shift-add (one partial product per cycle).
REQ-018 SHALL compute DIV/REM with quotient truncated toward zero and remainder sign equal to dividend sign, via restoring/non-restoring division on magnitudes (one quotient bit per cycle).
REQ-019 SHALL, for b==0: DIV/DIVU res = all ones, REM/REMU res = a, C=1; latency unchanged.
REQ-020 SHALL, for DIV/REM with a = most-negative and b = -1: DIV res = a, REM res = 0, V=1.
REQ-021 SHALL force C=0 and V=0 for all multiply ops and for non-exceptional divides.
REQ-022 SHALL hold res and flags stable from the done cycle until the next done cycle.
REQ-023 SHALL NOT produce X on any output when inputs are known.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, enter IDLE with busy=0, done=0, res=0, flags=4'b0100.
REQ-025 SHALL abort an in-flight operation on reset with no done pulse; start in the same cycle as rst SHALL be ignored.
REQ-026 SHALL accept a new start on the first edge after rst deasserts.

Verification
REQ-027 SHALL verify (WIDTH=32) MUL a=7, b=-3 -> res=32'hffffffeb, flags=4'b1000, done exactly 33 cycles after start edge.
REQ-028 SHALL verify MULHU a=b=32'hffffffff -> res=32'hfffffffe, flags=4'b1000; MULH a=b=-1 -> res=0, flags=4'b0100.
REQ-029 SHALL verify DIV a=-7, b=2 -> res=-3 (flags 4'b1000); REM a=-7, b=2 -> res=-1 (flags 4'b1000).
REQ-030 SHALL verify DIVU a=5, b=0 -> res=32'hffffffff, flags=4'b1010; REMU a=5, b=0 -> res=5, flags=4'b0010; DIV a=32'h80000000, b=-1 -> res=32'h80000000, flags=4'b1001.
REQ-031 SHALL verify start pulsed with new operands 5 cycles into a DIV is ignored (original result returned, single done), and rst at cycle 10 of a MUL yields no done, outputs at reset values.
REQ-032 SHALL verify WIDTH=8 instance: DIV a=8'h80, b=8'hff -> res=8'h80, flags=4'b1001, done 9 cycles after start edge.
